// File: rtl/mips_int_ctrl.sv
// Edge-detected, maskable, fixed-priority interrupt controller feeding the mips core.
// Define INTC_SYNC_EN to put a 2-flop synchroniser in front of each irq_in bit.
module mips_int_ctrl_lane (
  input  logic clk,
  input  logic rst,
  input  logic irq_raw,
  input  logic clr,
  output logic pend,
  output logic ovr
);
  logic irq_s, irq_q, evt;

`ifdef INTC_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk)
    if (!rst) sync <= '0;
    else      sync <= {sync[0], irq_raw};
  assign irq_s = sync[1];
`else
  assign irq_s = irq_raw;
`endif

  assign evt = irq_s & ~irq_q;
  // an edge landing on the channel being acked re-arms it and is not a loss
  assign ovr = evt & pend & ~clr;

  always_ff @(posedge clk)
    if (!rst) begin
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_q <= irq_s;
      if (evt)      pend <= 1'b1;
      else if (clr) pend <= 1'b0;
    end
endmodule

module mips_int_ctrl #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             interrupter,
  output logic [ID_W-1:0]  int_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic [CNT_W-1:0] overrun_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
  state_t state;

  logic [N_IRQ-1:0] elig, clr, ovr;
  logic [ID_W-1:0]  win;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_lane
    assign clr[g] = (state == REQ) & int_ack & (int_id == ID_W'(g));
    mips_int_ctrl_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .irq_raw (irq_in[g]),
      .clr     (clr[g]),
      .pend    (pending[g]),
      .ovr     (ovr[g])
    );
  end

  assign elig = pending & mask;

  // scan high to low so the lowest eligible index is the last write
  always_comb begin
    win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (elig[i]) win = ID_W'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      interrupter <= 1'b0;
      int_id      <= '0;
    end else begin
      case (state)
        IDLE: if (|elig) begin
          int_id      <= win;
          interrupter <= 1'b1;
          state       <= REQ;
        end
        REQ: if (int_ack) begin
          interrupter <= 1'b0;
          state       <= SERV;
        end
        SERV: if (int_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (!rst)         mask <= '1;
    else if (mask_we) mask <= mask_wdata;

  // simultaneous losses on several channels count once
  always_ff @(posedge clk)
    if (!rst)                            overrun_cnt <= '0;
    else if (|ovr && overrun_cnt != '1)  overrun_cnt <= overrun_cnt + 1'b1;
endmodule

// File: doc/mips_int_ctrl.md
# mips_int_ctrl

Parametrised interrupt controller placed between external interrupt sources and the `interrupter` input of the `mips` core. It generalises the single raw interrupt line into `N_IRQ` edge-detected, maskable, fixed-priority channels. Each request is held until the core acknowledges it and signals completion. Lost edges are counted per controller for debug readout.

## Interface
- `N_IRQ`, 4, number of interrupt channels (1..16)
- `ID_W`, 2, width of the channel id; must satisfy 2^ID_W >= N_IRQ
- `CNT_W`, 8, width of the overrun counter
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  reset, synchronous, active-low (0 = reset, sampled on rising `clk`)
- `irq_in`  in  N_IRQ  raw interrupt sources, level, rising edge = event
- `mask_we`  in  1  mask write strobe
- `mask_wdata`  in  N_IRQ  new mask value; 1 = channel enabled
- `int_ack`  in  1  core has taken the interrupt (1-cycle pulse)
- `int_done`  in  1  core finished the handler (eret), 1-cycle pulse
- `interrupter`  out  1  request to `mips`
- `int_id`  out  ID_W  id of the requested or in-service channel
- `pending`  out  N_IRQ  pending bits, unmasked view
- `mask`  out  N_IRQ  current mask
- `overrun_cnt`  out  CNT_W  saturating count of lost edges

## Operation
- Edge detect per channel: `irq_q` is the registered copy of the (optionally synchronised) input. An event is `irq_s & ~irq_q`.
- An event sets `pending[i]`.
- If `pending[i]` is already 1 when an event arrives, it stays 1 and `overrun_cnt` increments. The counter saturates at all-ones.
- Several channels with overrun in the same cycle add 1 to the counter, not N.
- Eligible set is `pending & mask`. Priority is fixed: the lowest index wins.
- FSM states are IDLE, REQ and SERV.
  - IDLE: if the eligible set is non-zero, latch the winner into `int_id` and go to REQ.
  - REQ: `interrupter`=1. `int_id` is frozen, even if a higher-priority channel becomes eligible. On `int_ack`, clear `pending[int_id]` and go to SERV.
  - SERV: `interrupter`=0 and `int_id` is held. On `int_done`, go to IDLE. No nesting.
- `int_ack` outside REQ and `int_done` outside SERV are ignored.
- Same-cycle event on `int_id` and ack-clear: set wins, so `pending` stays 1 and no overrun is counted.
- Mask write takes effect on the next edge. Masking the channel held in REQ does not withdraw the request. Masked channels still latch pending.
- Reset values:
  - FSM = IDLE
  - `interrupter`=0, `int_id`=0, `pending`=0, `overrun_cnt`=0
  - `mask` = all-ones
  - `irq_q` and synchroniser stages = 0
- Reset mid-operation (REQ or SERV) returns to IDLE immediately and discards all pending events.

## Timing
- Without the synchroniser: `irq_in` sampled high at edge k with `irq_q`=0 gives `pending` set after edge k. The FSM enters REQ and `interrupter`=1 after edge k+1. Latency is 2 cycles.
- With the synchroniser: add 2 cycles, for 4 total.
- `int_ack` sampled at edge a gives `interrupter`=0 and the pending bit cleared after edge a.
- `int_done` at edge d gives IDLE after edge d. The next request can be asserted after edge d+1.
- Minimum `irq_in` low time between distinct events is 1 sampled cycle.
- All outputs are registered.

## Configuration
- `INTC_SYNC_EN`:
  - Defined: a 2-flop synchroniser on each `irq_in` bit precedes edge detection, and event latency is 4 cycles.
  - Undefined: `irq_in` feeds edge detection directly (synchronous sources only), and event latency is 2 cycles.
  - All other behaviour is identical.

## Test plan
- Reset and single event, N_IRQ=4, no sync:
  - Stimulus: hold `rst`=0 for 2 cycles; pulse `irq_in[2]` for 2 cycles; ack 3 cycles after `interrupter` rises; done 5 cycles later.
  - Required: `interrupter`=1 two edges after the rise; `int_id`=2; `pending`=4'b0100 then 0 after ack; back to IDLE after done.
- Priority:
  - Stimulus: `irq_in`=4'b1010 in the same cycle.
  - Required: `int_id`=1 served first; after done, `int_id`=3 is requested on the next cycle.
- Mask:
  - Stimulus: write `mask`=4'b1110, then pulse `irq_in[0]`.
  - Required: `pending[0]`=1 and no request.
  - Stimulus: write `mask`=4'b1111.
  - Required: request with `int_id`=0 within 2 cycles.
- Overrun and saturation:
  - Stimulus: with CNT_W=2, generate 5 edges on channel 3 while it is in SERV.
  - Required: `overrun_cnt` reaches 3 and holds. An edge coinciding with the ack cycle leaves `pending[3]`=1 and the counter unchanged.
- Reset mid-service:
  - Stimulus: assert `rst`=0 in SERV with `pending`=4'b0011.
  - Required: all outputs at reset values after that edge; `mask`=4'b1111.
- Synchroniser build:
  - Stimulus: rerun the single-event case with `INTC_SYNC_EN`.
  - Required: `interrupter` rises 4 edges after `irq_in`.
